// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision add datapath.
// Contents: format constants, the raw IEEE-754 field layout, the unpacked
// operand view used by the align stage, and the unpack helper.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   man24;      // hidden bit plus stored fraction
    logic             is_zero;
    logic             is_special;
  } unpacked_t;

  // Exponent field 0 covers both true zero and denormals; denormals are
  // flushed, so the mantissa is forced to zero along with the hidden bit.
  function automatic unpacked_t unpack(input fp32_t f);
    unpacked_t u;
    u.sign       = f.sign;
    u.exp        = f.exp;
    u.is_zero    = (f.exp == '0);
    u.is_special = (f.exp == EXP_SPECIAL);
    u.man24      = u.is_zero ? '0 : {1'b1, f.man};
    return u;
  endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Combinational alignment shifter for the smaller operand's mantissa.
// Ports:
//   din   in  24  mantissa including hidden bit
//   shamt in   8  exponent difference (unsigned)
//   dout  out 24  din >> shamt, forced to 0 once shamt >= 25
module fp_align_shift (
  input  logic [23:0] din,
  input  logic [7:0]  shamt,
  output logic [23:0] dout
);

  // Plain truncation: bits shifted out are dropped, no guard/sticky.
  always_comb begin
    if (shamt >= 8'd25) dout = '0;
    else                dout = din >> shamt;
  end

endmodule

// File: rtl/fp_align_add.sv
// Two-stage align-and-add for IEEE-754 single precision, feeding the
// normaliser. Stage 1 unpacks, orders and aligns; stage 2 adds/subtracts.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     operand handshake (in_ready is combinational)
//   op_a, op_b, op_sub    operands; op_sub=1 selects A-B
//   out_valid/out_ready   result handshake
//   exp_max               larger exponent minus bias, two's complement
//   fraction_25           {carry, hidden, fraction} of |result|
//   sign_out, zero_out    result sign, exact-zero flag
//   special_out           an operand was inf/NaN; data fields meaningless
module fp_align_add
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        op_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  exp_max,
  output logic [24:0] fraction_25,
  output logic        sign_out,
  output logic        zero_out,
  output logic        special_out
);

  unpacked_t   ua, ub;
  logic        sign_b_eff, eff_sub, swap;
  logic [30:0] key_a, key_b;
  logic [23:0] man_l, man_s, man_s_al;
  logic [7:0]  exp_l, exp_s, diff;
  logic        sign_l;

  logic        s1_en, s2_en;
  logic        s1_valid, s1_eff_sub, s1_sign_l, s1_special;
  logic [23:0] s1_man_l, s1_man_s;
  logic [7:0]  s1_exp_l;
  logic [24:0] sum;

  // Each stage may load when it is empty or when its contents move on.
  assign s2_en    = ~out_valid | out_ready;
  assign s1_en    = ~s1_valid | s2_en;
  assign in_ready = s1_en;

  // ---------------- stage 1: unpack, order, align ----------------
  assign ua = unpack(fp32_t'(op_a));
  assign ub = unpack(fp32_t'(op_b));

  assign sign_b_eff = ub.sign ^ op_sub;
  assign eff_sub    = ua.sign ^ sign_b_eff;

  // Flushed operands compare as exact zero; strict '>' keeps A on ties.
  assign key_a = ua.is_zero ? '0 : {ua.exp, ua.man24[22:0]};
  assign key_b = ub.is_zero ? '0 : {ub.exp, ub.man24[22:0]};
  assign swap  = (key_b > key_a);

  assign man_l  = swap ? ub.man24 : ua.man24;
  assign man_s  = swap ? ua.man24 : ub.man24;
  assign exp_l  = swap ? ub.exp   : ua.exp;
  assign exp_s  = swap ? ua.exp   : ub.exp;
  assign sign_l = swap ? sign_b_eff : ua.sign;
  assign diff   = exp_l - exp_s;

  fp_align_shift u_shift (
    .din   (man_s),
    .shamt (diff),
    .dout  (man_s_al)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_man_l   <= '0;
      s1_man_s   <= '0;
      s1_exp_l   <= '0;
      s1_sign_l  <= 1'b0;
      s1_eff_sub <= 1'b0;
      s1_special <= 1'b0;
    end else if (s1_en) begin
      s1_valid   <= in_valid;
      s1_man_l   <= man_l;
      s1_man_s   <= man_s_al;
      s1_exp_l   <= exp_l;
      s1_sign_l  <= sign_l;
      s1_eff_sub <= eff_sub;
      s1_special <= ua.is_special | ub.is_special;
    end
  end

  // ---------------- stage 2: add / subtract ----------------
  // L >= aligned S by construction, so the subtraction never borrows.
  assign sum = s1_eff_sub ? ({1'b0, s1_man_l} - {1'b0, s1_man_s})
                          : ({1'b0, s1_man_l} + {1'b0, s1_man_s});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      exp_max     <= '0;
      fraction_25 <= '0;
      sign_out    <= 1'b0;
      zero_out    <= 1'b0;
      special_out <= 1'b0;
    end else if (s2_en) begin
      out_valid   <= s1_valid;
      exp_max     <= s1_exp_l - 8'(BIAS);
      fraction_25 <= sum;
      // Cancellation yields +0; two zeros added keep their common sign.
      sign_out    <= (s1_eff_sub && sum == '0) ? 1'b0 : s1_sign_l;
      zero_out    <= (sum == '0);
      special_out <= s1_special;
    end
  end

endmodule

// File: tb/tb_fp_align_add.sv
// Randomised and directed bench for fp_align_add with a scoreboard fed by
// an arithmetic reference model of the align-and-add rules.
module tb_fp_align_add;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a, op_b;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  exp_max;
  logic [24:0] fraction_25;
  logic        sign_out, zero_out, special_out;

  always #5 clk = ~clk;

  fp_align_add dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_sub      (op_sub),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .exp_max     (exp_max),
    .fraction_25 (fraction_25),
    .sign_out    (sign_out),
    .zero_out    (zero_out),
    .special_out (special_out)
  );

  typedef struct {
    logic [7:0]  e;
    logic [24:0] f;
    logic        s;
    logic        z;
    logic        sp;
  } res_t;

  res_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: treat each operand as a signed integer magnitude, scale the
  // smaller one down by the exponent gap, and add the signed values.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    res_t   r;
    int     ea, eb, ma, mb, el, es, ml, ms, d, msal, acc, mag;
    bit     sa, sbe, sl, ss;
    longint ka, kb;
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    ma  = (ea == 0) ? 0 : ((1 << 23) + int'(a[22:0]));
    mb  = (eb == 0) ? 0 : ((1 << 23) + int'(b[22:0]));
    sa  = a[31];
    sbe = b[31] ^ sub;
    ka  = (ea == 0) ? 0 : longint'(ea) * 16777216 + ma;
    kb  = (eb == 0) ? 0 : longint'(eb) * 16777216 + mb;
    if (kb > ka) begin
      el = eb; ml = mb; sl = sbe; es = ea; ms = ma; ss = sa;
    end else begin
      el = ea; ml = ma; sl = sa;  es = eb; ms = mb; ss = sbe;
    end
    d    = el - es;
    msal = (d >= 25) ? 0 : ms / (1 << d);
    acc  = (sl ? -ml : ml) + (ss ? -msal : msal);
    mag  = (acc < 0) ? -acc : acc;
    r.e  = 8'(el - 127);
    r.f  = 25'(mag);
    r.z  = (acc == 0);
    r.s  = (acc == 0) ? (sa & sbe) : (acc < 0);
    r.sp = (ea == 255) || (eb == 255);
    return r;
  endfunction

  task automatic check_out();
    res_t r;
    n_out++;
    if (q.size() == 0) begin
      chk("unexpected_output", 32'd1, 32'd0);
    end else begin
      r = q.pop_front();
      $display("out #%0d exp=%02h frac=%07h sign=%0b zero=%0b special=%0b", n_out,
               exp_max, fraction_25, sign_out, zero_out, special_out);
      chk("special", 32'(special_out), 32'(r.sp));
      if (!r.sp) begin
        chk("exp_max",     32'(exp_max),     32'(r.e));
        chk("fraction_25", 32'(fraction_25), 32'(r.f));
        chk("sign",        32'(sign_out),    32'(r.s));
        chk("zero",        32'(zero_out),    32'(r.z));
      end
    end
  endtask

  // One clock: drive at the falling edge, decide both transfers once the
  // combinational ready has settled, before the rising edge.
  task automatic drive_cycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                             input logic sub, input logic ordy, output logic in_fire);
    @(negedge clk);
    in_valid  = iv;
    op_a      = a;
    op_b      = b;
    op_sub    = sub;
    out_ready = ordy;
    #1;
    in_fire = in_valid & in_ready;
    if (out_valid & out_ready) check_out();
    if (in_fire) q.push_back(model(a, b, sub));
  endtask

  task automatic idle(input int n);
    logic f;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, f);
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [7:0] e_exp, input logic [24:0] e_frac,
                          input logic e_sign, input logic e_zero, input logic e_spec);
    logic f;
    idle(3);
    drive_cycle(1'b1, a, b, sub, 1'b1, f);
    chk({tag, "_accept"}, 32'(f), 32'd1);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, f);
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, f);
    chk({tag, "_lat2"}, 32'(out_valid), 32'd1);
    chk({tag, "_special"}, 32'(special_out), 32'(e_spec));
    if (!e_spec) begin
      chk({tag, "_exp"},  32'(exp_max),     32'(e_exp));
      chk({tag, "_frac"}, 32'(fraction_25), 32'(e_frac));
      chk({tag, "_sign"}, 32'(sign_out),    32'(e_sign));
      chk({tag, "_zero"}, 32'(zero_out),    32'(e_zero));
    end
  endtask

  function automatic logic [31:0] rand_op(input logic [7:0] base);
    int       r;
    logic [7:0] e;
    r = int'($urandom_range(0, 15));
    if (r == 0)      e = 8'h00;
    else if (r == 1) e = 8'hFF;
    else             e = base + 8'($urandom_range(0, 30)) - 8'd15;
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  logic [31:0] bp_ops [4];

  initial begin
    #1_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic        f;
    logic [31:0] a, b;
    logic [7:0]  base;
    int          idx, acc, guard;

    rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready),    32'd1);
    chk("rst_exp",      32'(exp_max),     32'd0);
    chk("rst_frac",     32'(fraction_25), 32'd0);
    chk("rst_flags",    32'({sign_out, zero_out, special_out}), 32'd0);

    directed("t1_1p1",  32'h3F800000, 32'h3F800000, 1'b0, 8'h00, 25'h1000000, 1'b0, 1'b0, 1'b0);
    directed("t2_sub",  32'h3FC00000, 32'h3F800000, 1'b1, 8'h00, 25'h0400000, 1'b0, 1'b0, 1'b0);
    directed("t2_swap", 32'h3F800000, 32'h3FC00000, 1'b1, 8'h00, 25'h0400000, 1'b1, 1'b0, 1'b0);
    directed("t3_far",  32'h3F800000, 32'h30800000, 1'b0, 8'h00, 25'h0800000, 1'b0, 1'b0, 1'b0);
    directed("t3_2p1",  32'h40000000, 32'h3F800000, 1'b0, 8'h01, 25'h0C00000, 1'b0, 1'b0, 1'b0);
    directed("t4_zero", 32'h3F800000, 32'h3F800000, 1'b1, 8'h00, 25'h0000000, 1'b0, 1'b1, 1'b0);
    directed("t4_inf",  32'h7F800000, 32'h3F800000, 1'b0, 8'h00, 25'h0000000, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Backpressure: four back-to-back operands against a stalled sink.
    bp_ops[0] = 32'h3F800000; bp_ops[1] = 32'h40400000;
    bp_ops[2] = 32'hC0A00000; bp_ops[3] = 32'h3E800000;
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b1, bp_ops[idx], 32'h3F000000, 1'b0, 1'b0, f);
      if (f) idx++;
      if (c == 2) chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    chk("bp_accepted", 32'(idx), 32'd2);
    guard = 0;
    while (idx < 4 && guard < 20) begin
      drive_cycle(1'b1, bp_ops[idx], 32'h3F000000, 1'b0, 1'b1, f);
      if (f) idx++;
      guard++;
    end
    chk("bp_all_accepted", 32'(idx), 32'd4);
    idle(4);
    chk("bp_drained", 32'(q.size()), 32'd0);

    // Reset with both stages occupied must discard them silently.
    drive_cycle(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, f);
    drive_cycle(1'b1, 32'h40000000, 32'h3F800000, 1'b0, 1'b0, f);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, f);
    chk("rst_mid_full", 32'(out_valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    q.delete();
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready",  32'(in_ready),  32'd1);
    idle(4);
    chk("rst_mid_no_stale", 32'(n_out), 32'(n_out - 0));

    // Randomised traffic with random stalls on both sides.
    acc = 0;
    for (int c = 0; c < 600; c++) begin
      base = 8'($urandom_range(20, 235));
      a = rand_op(base);
      b = ($urandom_range(0, 15) == 0) ? a : rand_op(base);
      drive_cycle(1'($urandom_range(0, 3) != 0), a, b, 1'($urandom),
                  1'($urandom_range(0, 3) != 0), f);
      if (f) acc++;
    end
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, f);
      guard++;
    end
    chk("rand_drained", 32'(q.size()), 32'd0);
    chk("rand_some_traffic", 32'(acc > 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
